sync_debounce: RTL and testbench

//   Debounce and edge-detect stage that sits directly downstream of sync_cell.
//   It consumes the already-synchronized level and filters out short glitches
//   by requiring DEBOUNCE_CYCLES consecutive identical samples.
//   It emits a clean level, one-cycle rise/fall pulses, a glitch pulse and a

---
 rtl/utils_sync_pkg.sv | 26 ++
 rtl/sync_debounce_sat_counter.sv | 36 +++
 rtl/sync_debounce.sv | 162 ++++++++++++++++
 tb/tb_sync_debounce.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/utils_sync_pkg.sv
// Shared definitions for the synchronizer / debounce family: FSM state
// encodings and the debounce counter width helper.
package utils_sync_pkg;

    // 2-bit encodings of the debounce FSM states
    localparam logic [1:0] ST_STABLE_LO = 2'b00;
    localparam logic [1:0] ST_PEND_HI   = 2'b01;
    localparam logic [1:0] ST_STABLE_HI = 2'b10;
    localparam logic [1:0] ST_PEND_LO   = 2'b11;

    typedef enum logic [1:0] {
        STABLE_LO = ST_STABLE_LO,
        PEND_HI   = ST_PEND_HI,
        STABLE_HI = ST_STABLE_HI,
        PEND_LO   = ST_PEND_LO
    } dbnc_state_e;

    // Width needed to hold a debounce count of 0..n; never narrower than 1 bit
    function automatic int dbnc_cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [EVT_W-1:0] count
);

    logic [EVT_W-1:0] count_q;
    logic [EVT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment until all-ones and stick there
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {EVT_W{1'b1}})) begin
            count_d = count_q + EVT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sync_debounce.sv
// Debounce and edge-detect stage fed by an already-synchronized level.
// A change on sync_in is accepted only after DEBOUNCE_CYCLES consecutive
// equal samples; aborted changes raise a one-cycle glitch pulse.
module sync_debounce
    import utils_sync_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EVT_W           = 8,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    input  logic             en,
    input  logic             evt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             glitch,
    output logic [EVT_W-1:0] evt_count
);

    localparam int CNT_W = dbnc_cnt_width(DEBOUNCE_CYCLES);
    // Count value at which the next matching sample completes the run
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam dbnc_state_e RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    dbnc_state_e      state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             level_q,  level_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic             glitch_q, glitch_d;

    // Next-state and registered-output logic of the debounce FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;

        if (!en) begin
            // Disabled: drop any pending change silently, stable states hold
            case (state_q)
                PEND_HI: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end
                PEND_LO: begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end
                default: begin
                end
            endcase
        end else begin
            case (state_q)
                STABLE_LO: begin
                    if (sync_in) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = STABLE_HI;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = PEND_HI;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PEND_HI: begin
                    if (sync_in) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = STABLE_HI;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d  = STABLE_LO;
                        glitch_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                STABLE_HI: begin
                    if (!sync_in) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = STABLE_LO;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = PEND_LO;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PEND_LO: begin
                    if (!sync_in) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = STABLE_LO;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d  = STABLE_HI;
                        glitch_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                default: begin
                    state_d = RESET_STATE;
                    level_d = RESET_LEVEL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, debounce count and registered outputs; reset beats everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    // Accepted edges are counted in the cycle their pulse is visible
    sat_counter #(
        .EVT_W (EVT_W)
    ) u_evt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rise_q | fall_q),
        .clr   (evt_clr),
        .count (evt_count)
    );

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch     = glitch_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: a vector table for the main DUT
// (N=4, EVT_W=8) and a hand-written toggle sequence for a narrow counter.
module tb_sync_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT
    logic       rst, sync_in, en, evt_clr;
    logic       level_out, rise_pulse, fall_pulse, glitch;
    logic [7:0] evt_count;

    sync_debounce #(.DEBOUNCE_CYCLES(4), .EVT_W(8), .RESET_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in), .en(en), .evt_clr(evt_clr),
        .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .glitch(glitch), .evt_count(evt_count)
    );

    // Narrow-counter DUT
    logic       rst2, sync_in2, en2, evt_clr2;
    logic       level2, rise2, fall2, glitch2;
    logic [1:0] evt_count2;

    sync_debounce #(.DEBOUNCE_CYCLES(4), .EVT_W(2), .RESET_LEVEL(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .sync_in(sync_in2), .en(en2), .evt_clr(evt_clr2),
        .level_out(level2), .rise_pulse(rise2), .fall_pulse(fall2),
        .glitch(glitch2), .evt_count(evt_count2)
    );

    typedef struct {
        logic       rst;
        logic       si;
        logic       en;
        logic       clr;
        logic       lvl;
        logic       rise;
        logic       fall;
        logic       glt;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic r, input logic s, input logic e, input logic c,
                       input logic l, input logic ri, input logic fa, input logic g,
                       input logic [7:0] n);
        vec_t v;
        v.rst = r; v.si = s; v.en = e; v.clr = c;
        v.lvl = l; v.rise = ri; v.fall = fa; v.glt = g; v.cnt = n;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; sync_in = 1'b0; en = 1'b1; evt_clr = 1'b0;
        rst2 = 1'b1; sync_in2 = 1'b0; en2 = 1'b1; evt_clr2 = 1'b0;

        //   rst si en clr | lvl rise fall glt cnt
        // reset held with sync_in high
        add(1, 1, 1, 0,   0, 0, 0, 0, 0);
        add(1, 1, 1, 0,   0, 0, 0, 0, 0);
        // release: 4th sampling edge accepts the high level
        add(0, 1, 1, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   1, 1, 0, 0, 0);
        add(0, 1, 1, 0,   1, 0, 0, 0, 1);
        add(0, 1, 1, 0,   1, 0, 0, 0, 1);
        // clean fall
        add(0, 0, 1, 0,   1, 0, 0, 0, 1);
        add(0, 0, 1, 0,   1, 0, 0, 0, 1);
        add(0, 0, 1, 0,   1, 0, 0, 0, 1);
        add(0, 0, 1, 0,   0, 0, 1, 0, 1);
        add(0, 0, 1, 0,   0, 0, 0, 0, 2);
        // three highs then low: glitch, no level change
        add(0, 1, 1, 0,   0, 0, 0, 0, 2);
        add(0, 1, 1, 0,   0, 0, 0, 0, 2);
        add(0, 1, 1, 0,   0, 0, 0, 0, 2);
        add(0, 0, 1, 0,   0, 0, 0, 1, 2);
        add(0, 0, 1, 0,   0, 0, 0, 0, 2);
        // en dropped at count=2: back to STABLE_LO silently
        add(0, 1, 1, 0,   0, 0, 0, 0, 2);
        add(0, 1, 1, 0,   0, 0, 0, 0, 2);
        add(0, 1, 0, 0,   0, 0, 0, 0, 2);
        add(0, 1, 0, 0,   0, 0, 0, 0, 2);
        // re-enabled: debounce restarts from one
        add(0, 1, 1, 0,   0, 0, 0, 0, 2);
        add(0, 1, 1, 0,   0, 0, 0, 0, 2);
        add(0, 1, 1, 0,   0, 0, 0, 0, 2);
        add(0, 1, 1, 0,   1, 1, 0, 0, 2);
        // clear during rise pulse wins; that edge is not counted
        add(0, 1, 1, 1,   1, 0, 0, 0, 0);
        add(0, 1, 1, 0,   1, 0, 0, 0, 0);
        // fall, with clear coinciding with the fall pulse
        add(0, 0, 1, 0,   1, 0, 0, 0, 0);
        add(0, 0, 1, 0,   1, 0, 0, 0, 0);
        add(0, 0, 1, 0,   1, 0, 0, 0, 0);
        add(0, 0, 1, 0,   0, 0, 1, 0, 0);
        add(0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, 0, 1, 0,   0, 0, 0, 0, 0);
        // back high, then reset in the middle of PEND_LO
        add(0, 1, 1, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   1, 1, 0, 0, 0);
        add(0, 1, 1, 0,   1, 0, 0, 0, 1);
        add(0, 0, 1, 0,   1, 0, 0, 0, 1);
        add(0, 0, 1, 0,   1, 0, 0, 0, 1);
        add(1, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, 0, 1, 0,   0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; sync_in = vq[i].si; en = vq[i].en; evt_clr = vq[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", i),  int'(level_out),  int'(vq[i].lvl));
            chk($sformatf("v%0d_rise", i),   int'(rise_pulse), int'(vq[i].rise));
            chk($sformatf("v%0d_fall", i),   int'(fall_pulse), int'(vq[i].fall));
            chk($sformatf("v%0d_glitch", i), int'(glitch),     int'(vq[i].glt));
            chk($sformatf("v%0d_count", i),  int'(evt_count),  int'(vq[i].cnt));
        end

        // Narrow counter: five clean toggles, count must stick at 3
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        chk("sat_reset_count", int'(evt_count2), 0);
        for (int t = 1; t <= 5; t++) begin
            sync_in2 = (t % 2 == 1) ? 1'b1 : 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
            end
            chk($sformatf("sat_t%0d_level", t), int'(level2), (t % 2 == 1) ? 1 : 0);
            chk($sformatf("sat_t%0d_count", t), int'(evt_count2), (t < 3) ? t : 3);
            chk($sformatf("sat_t%0d_quiet", t), int'(rise2 | fall2 | glitch2), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
